// File: rtl/vga_pkg.sv
// Shared VGA definitions: visible-area defaults and test-pattern codes.
// Used by vga_controller and the pattern sequencer.
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_V_VISIBLE = 480;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_GRID    = 2'd2,
    PAT_BORDER  = 2'd3
  } pattern_t;

  // Pattern order wraps BORDER -> BARS through the 2-bit code.
  function automatic pattern_t next_pattern(input pattern_t p);
    return pattern_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/vga_pattern_sequencer_if.sv
// Video bus between vga_controller timing and the RGB pins: timing in, pixel and syncs out.
interface vga_pattern_sequencer_if;
  logic       visible;
  logic [9:0] row;
  logic [9:0] col;
  logic       h_sync;
  logic       v_sync;
  logic       R;
  logic       G;
  logic       B;
  logic       h_sync_q;
  logic       v_sync_q;

  modport master (
    output visible, row, col, h_sync, v_sync,
    input  R, G, B, h_sync_q, v_sync_q
  );

  modport slave (
    input  visible, row, col, h_sync, v_sync,
    output R, G, B, h_sync_q, v_sync_q
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern pixel function; blanking forces black.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int V_VISIBLE = VGA_V_VISIBLE
) (
  input  pattern_t   pattern,
  input  logic [9:0] row,
  input  logic [9:0] col,
  input  logic       visible,
  output logic [2:0] rgb
);

  localparam logic [9:0] H_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] H_MID  = 10'(H_VISIBLE / 2);
  localparam logic [9:0] V_MID  = 10'(V_VISIBLE / 2);

  logic edge_hit;
  logic mid_hit;

  assign edge_hit = (row == 10'd0) || (row == H_LAST) || (col == 10'd0) || (col == V_LAST);
  assign mid_hit  = (row == H_MID) || (col == V_MID);

  always_comb begin
    rgb = 3'd0;
    if (visible) begin
      unique case (pattern)
        PAT_BARS:    rgb = 3'd7 - row[9:7];
        PAT_CHECKER: rgb = {3{row[5] ^ col[5]}};
        PAT_GRID:    rgb = {3{(row[4:0] == 5'd0) || (col[4:0] == 5'd0)}};
        PAT_BORDER:  rgb = {edge_hit, mid_hit, 1'b0};
        default:     rgb = 3'd0;
      endcase
    end
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern sequencer: auto/manual pattern advance applied only
// at frame start, with RGB registered and syncs delayed one cycle to stay aligned.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int FRAMES_PER_PATTERN = 30,
  parameter int H_VISIBLE          = VGA_H_VISIBLE,
  parameter int V_VISIBLE          = VGA_V_VISIBLE
) (
  input  logic                          pixel_clk,
  input  logic                          reset,
  vga_pattern_sequencer_if.slave        vid,
  input  logic                          advance,
  input  logic                          hold,
  output logic [1:0]                    pattern,
  output logic                          frame_tick
);

  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_PATTERN - 1);

  logic       adv_meta;
  logic       adv_sync;
  logic       adv_sync_d;
  logic       adv_pending;
  logic       v_sync_d;
  logic [7:0] frame_cnt;
  pattern_t   pat;
  logic [2:0] rgb_p0;
  logic       frame_start;
  logic       adv_rise;

  assign frame_start = v_sync_d & ~vid.v_sync;
  assign adv_rise    = adv_sync & ~adv_sync_d;
  assign pattern     = pat;

  vga_pattern_gen #(
    .H_VISIBLE (H_VISIBLE),
    .V_VISIBLE (V_VISIBLE)
  ) u_gen (
    .pattern (pat),
    .row     (vid.row),
    .col     (vid.col),
    .visible (vid.visible),
    .rgb     (rgb_p0)
  );

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      adv_meta     <= 1'b0;
      adv_sync     <= 1'b0;
      adv_sync_d   <= 1'b0;
      adv_pending  <= 1'b0;
      v_sync_d     <= 1'b1;
      frame_cnt    <= 8'd0;
      pat          <= PAT_BARS;
      frame_tick   <= 1'b0;
      vid.R        <= 1'b0;
      vid.G        <= 1'b0;
      vid.B        <= 1'b0;
      vid.h_sync_q <= 1'b1;
      vid.v_sync_q <= 1'b1;
    end else begin
      adv_meta   <= advance;
      adv_sync   <= adv_meta;
      adv_sync_d <= adv_sync;
      v_sync_d   <= vid.v_sync;
      frame_tick <= frame_start;

      // p0 -> output stage: pixel and syncs leave together one cycle after sampling
      {vid.R, vid.G, vid.B} <= rgb_p0;
      vid.h_sync_q          <= vid.h_sync;
      vid.v_sync_q          <= vid.v_sync;

      // A press detected on the frame-start edge itself survives for the next frame
      if (adv_rise)
        adv_pending <= 1'b1;
      else if (frame_start)
        adv_pending <= 1'b0;

      if (frame_start) begin
        if (adv_pending) begin
          pat       <= next_pattern(pat);
          frame_cnt <= 8'd0;
        end else if (hold) begin
          frame_cnt <= 8'd0;
        end else if (frame_cnt == CNT_LAST) begin
          pat       <= next_pattern(pat);
          frame_cnt <= 8'd0;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scoreboard bench for vga_pattern_sequencer with short synthetic frames and random pixels.
module tb_vga_pattern_sequencer;
  import vga_pkg::*;

  localparam int FPP       = 30;
  localparam int FRAME_LEN = 40;

  logic       pixel_clk = 1'b0;
  logic       reset     = 1'b0;
  logic       advance;
  logic       hold;
  logic [1:0] pattern;
  logic       frame_tick;

  vga_pattern_sequencer_if vid();

  vga_pattern_sequencer #(.FRAMES_PER_PATTERN(FPP)) dut (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
    .vid        (vid),
    .advance    (advance),
    .hold       (hold),
    .pattern    (pattern),
    .frame_tick (frame_tick)
  );

  always #20 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic [1:0] pat;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   tick_cnt = 0;

  // Reference model state: pattern, frames elapsed since last change, pending press edges
  bit   adv_drv = 1'b0;
  bit   hold_drv = 1'b0;
  int   m_pat, m_since, cyc;
  bit   adv_prev, vs_prev;
  int   pend_q[$];

  function automatic logic [2:0] ref_pixel(input int pat, input int r, input int c, input bit vis);
    if (!vis) return 3'd0;
    case (pat)
      0: return 3'(7 - r / 128);
      1: return (((r / 32) + (c / 32)) % 2 == 1) ? 3'd7 : 3'd0;
      2: return ((r % 32 == 0) || (c % 32 == 0)) ? 3'd7 : 3'd0;
      default: return {(r == 0 || r == 639 || c == 0 || c == 479), (r == 320 || c == 240), 1'b0};
    endcase
  endfunction

  task automatic model_reset();
    m_pat = 0; m_since = 0; adv_prev = 1'b0; vs_prev = 1'b1;
    pend_q.delete();
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_pat(input string name, input int want);
    @(posedge pixel_clk); #1;
    check(name, int'(pattern), want);
  endtask

  // Drive one cycle of inputs and push what the outputs must show after the coming edge
  task automatic step(input bit vis, input int r, input int c, input bit hs, input bit vs);
    exp_t e;
    bit fs, pressed;
    int keep[$];
    @(negedge pixel_clk);
    vid.visible = vis; vid.row = 10'(r); vid.col = 10'(c);
    vid.h_sync = hs; vid.v_sync = vs;
    advance = adv_drv; hold = hold_drv;
    cyc++;
    if (adv_drv && !adv_prev) pend_q.push_back(cyc + 2);
    adv_prev = adv_drv;
    fs = !vs && vs_prev;
    vs_prev = vs;
    e.rgb = ref_pixel(m_pat, r, c, vis);
    e.hs = hs; e.vs = vs; e.tick = fs;
    if (fs) begin
      pressed = 1'b0;
      foreach (pend_q[i]) if (pend_q[i] < cyc) pressed = 1'b1; else keep.push_back(pend_q[i]);
      pend_q = keep;
      if (pressed) begin
        m_pat = (m_pat + 1) % 4; m_since = 0;
      end else if (hold_drv) begin
        m_since = 0;
      end else begin
        m_since++;
        if (m_since == FPP) begin m_pat = (m_pat + 1) % 4; m_since = 0; end
      end
    end
    e.pat = 2'(m_pat);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, 1'b1);
  endtask

  // One synthetic frame: v_sync low for 3 cycles, short h_sync pulses, directed boundary pixels
  task automatic frame(input int n, input int p1, input int p2);
    bit vis, hs, vs;
    int r, c;
    for (int i = 0; i < n; i++) begin
      vs  = (i >= 3);
      hs  = (i % 8 != 7);
      vis = (i >= 6) && (i < FRAME_LEN - 2);
      r = int'($urandom_range(0, 639));
      c = int'($urandom_range(0, 479));
      if (vis && $urandom_range(0, 9) == 0) vis = 1'b0;
      if (!vis) begin r = int'($urandom_range(0, 1023)); c = int'($urandom_range(0, 1023)); end
      case (i)
        10: begin vis = 1'b1; r = 300; end
        11: begin vis = 1'b0; r = 300; end
        12: begin vis = 1'b1; r = 320; end
        13: begin vis = 1'b1; r = 0; end
        14: begin vis = 1'b1; r = 639; end
        16: begin vis = 1'b1; c = 479; end
        17: begin vis = 1'b1; c = 240; end
        18: begin vis = 1'b1; r = 32 * int'($urandom_range(0, 19)); end
        default: ;
      endcase
      adv_drv = (p1 >= 0 && i >= p1 && i < p1 + 4) || (p2 >= 0 && i >= p2 && i < p2 + 2);
      step(vis, r, c, hs, vs);
    end
    adv_drv = 1'b0;
  endtask

  // Monitor: every clock presents a pixel, so pop one expectation per edge once stimulus runs
  initial begin
    exp_t e, got;
    forever begin
      @(posedge pixel_clk); #1;
      if (frame_tick === 1'b1) tick_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {vid.R, vid.G, vid.B, vid.h_sync_q, vid.v_sync_q, pattern, frame_tick};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got rgb=%b hs=%b vs=%b pat=%0d tick=%b, want rgb=%b hs=%b vs=%b pat=%0d tick=%b",
                   $time, got.rgb, got.hs, got.vs, got.pat, got.tick, e.rgb, e.hs, e.vs, e.pat, e.tick);
        end
      end
    end
  end

  initial begin
    #(60000 * 40);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int tick_base;
    vid.visible = 1'b0; vid.row = '0; vid.col = '0; vid.h_sync = 1'b1; vid.v_sync = 1'b1;
    advance = 1'b0; hold = 1'b0; cyc = 0;
    model_reset();

    #1 reset = 1'b1;
    #2;
    check("reset_rgb", int'({vid.R, vid.G, vid.B}), 0);
    check("reset_hsync_q", int'(vid.h_sync_q), 1);
    check("reset_vsync_q", int'(vid.v_sync_q), 1);
    check("reset_pattern", int'(pattern), 0);
    check("reset_tick", int'(frame_tick), 0);
    repeat (3) @(posedge pixel_clk);
    #5 reset = 1'b0;
    model_reset();
    tick_base = tick_cnt;
    idle(4);

    // Auto advance on the 30th frame start
    for (int k = 0; k < FPP; k++) begin
      frame(FRAME_LEN, -1, -1);
      if (k == FPP - 2) check_pat("auto_before_30th", 0);
    end
    check_pat("auto_at_30th", 1);
    check("auto_tick_count", tick_cnt - tick_base, FPP);

    // Manual press mid-frame, then coincident press with auto expiry
    repeat (5) frame(FRAME_LEN, -1, -1);
    frame(FRAME_LEN, 12, -1);
    frame(FRAME_LEN, -1, -1);
    check_pat("manual_step", 2);
    repeat (28) frame(FRAME_LEN, -1, -1);
    check_pat("manual_count_restart", 2);
    frame(FRAME_LEN, 15, -1);
    frame(FRAME_LEN, -1, -1);
    check_pat("coincident_single_step", 3);

    // Hold suppresses auto advance; presses still step and wrap
    hold_drv = 1'b1;
    repeat (100) frame(FRAME_LEN, -1, -1);
    check_pat("hold_100_frames", 3);
    for (int k = 0; k < 8; k++) begin
      frame(FRAME_LEN, (k < 7) ? 12 : -1, (k == 2) ? 25 : -1);
      if (k > 0) check_pat("press_wrap", (3 + k) % 4);
    end

    // Bring frame count to 17 at pattern GRID, then reset mid-frame
    hold_drv = 1'b0;
    repeat (16) frame(FRAME_LEN, -1, -1);
    frame(16, -1, -1);
    check_pat("pre_reset_pattern", 2);
    @(negedge pixel_clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_rgb", int'({vid.R, vid.G, vid.B}), 0);
    check("midreset_hsync_q", int'(vid.h_sync_q), 1);
    check("midreset_vsync_q", int'(vid.v_sync_q), 1);
    check("midreset_pattern", int'(pattern), 0);
    repeat (3) @(posedge pixel_clk);
    #5 reset = 1'b0;
    model_reset();
    tick_base = tick_cnt;
    idle(5);
    repeat (FPP - 1) frame(FRAME_LEN, -1, -1);
    check_pat("post_reset_before_30th", 0);
    frame(FRAME_LEN, -1, -1);
    check_pat("post_reset_at_30th", 1);
    check("post_reset_tick_count", tick_cnt - tick_base, FPP);

    repeat (2) @(posedge pixel_clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_sequencer.md
# vga_pattern_sequencer

Frame-synchronous test-pattern controller between `vga_controller` and the RGB pins. Pattern selection advances automatically every `FRAMES_PER_PATTERN` frames or on a button press, and only ever changes at a frame boundary, so no frame shows a torn pattern. The block registers the pattern pixel and delays the syncs to match, which keeps RGB and sync aligned at the pins.

## Interface
- `FRAMES_PER_PATTERN`, 30, frames per pattern in auto mode (0.5 s at 60 Hz); legal range 1..255.
- `H_VISIBLE`, 640, visible pixels per line.
- `V_VISIBLE`, 480, visible lines per frame.

Ports:
- `pixel_clk`  in  1  25 MHz pixel clock (PLL output); only clock.
- `reset`  in  1  asynchronous, active-high.
- `visible`  in  1  high when `row`/`col` lie in the active area.
- `row`  in  10  horizontal pixel index, 0..639 in the active area.
- `col`  in  10  vertical line index, 0..479 in the active area.
- `h_sync`  in  1  active-low horizontal sync from `vga_controller`.
- `v_sync`  in  1  active-low vertical sync from `vga_controller`.
- `advance`  in  1  asynchronous push-button, active-high.
- `hold`  in  1  level; high suppresses auto-advance.
- `R`, `G`, `B`  out  1 each  registered pixel colour.
- `h_sync_q`, `v_sync_q`  out  1 each  syncs delayed one cycle.
- `pattern`  out  2  current pattern code.
- `frame_tick`  out  1  one-cycle pulse per frame start.

## Operation
- **Frame start:** a falling edge of `v_sync`, detected by comparing `v_sync` with its registered copy `v_sync_d`.
- **Button path:**
  - `advance` passes through a 2-FF synchronizer, then a rising-edge detect.
  - A detected edge sets `adv_pending`.
  - `adv_pending` clears at the next frame start.
- **Frame counter:** `frame_cnt` is 8 bits. At each frame start it is updated by the first matching rule:
  - `adv_pending` set: `pattern <= pattern+1`, `frame_cnt <= 0`.
  - `hold` high: `frame_cnt <= 0`, `pattern` unchanged.
  - `frame_cnt == FRAMES_PER_PATTERN-1`: `pattern <= pattern+1`, `frame_cnt <= 0`.
  - Otherwise: `frame_cnt <= frame_cnt+1`.
- **Pattern state machine:** 0 BARS → 1 CHECKER → 2 GRID → 3 BORDER → 0. The 2-bit code wraps.
  - A manual edge and an auto expiry at the same frame start advance the pattern by exactly one.
  - Multiple button edges within one frame count as one advance.
- **Pixel functions** (applied when `visible`=1):
  - BARS: `{R,G,B} = 3'd7 - row[9:7]`, giving 7,6,5,4,3 across the five 128-px bars.
  - CHECKER: `R=G=B = row[5]^col[5]`.
  - GRID: `R=G=B = (row[4:0]==0)||(col[4:0]==0)`.
  - BORDER: `R = (row==0)||(row==H_VISIBLE-1)||(col==0)||(col==V_VISIBLE-1)`; `G = (row==H_VISIBLE/2)||(col==V_VISIBLE/2)`; `B = 0`.
- **Blanking:** `visible`=0 forces `{R,G,B}=0` regardless of pattern.
- **Pattern select timing:** the pixel function uses the registered `pattern`, so a change takes effect on the first pixel after the frame start.

## Timing
- **Reset values** (asynchronous):
  - `R`, `G`, `B`, `pattern`, `frame_tick`, `frame_cnt`, `adv_pending`, synchronizer FFs: 0.
  - `h_sync_q`, `v_sync_q`, `v_sync_d`: 1 (inactive).
- **Pixel latency:** exactly 1 cycle. `R`/`G`/`B`/`h_sync_q`/`v_sync_q` at edge n+1 reflect `row`/`col`/`visible`/syncs sampled at edge n.
- **`frame_tick`:** high for the single cycle following the edge at which `v_sync`=0 and `v_sync_d`=1. `pattern` updates on the same edge that raises `frame_tick`.
- **Button latency:** an `advance` rise reaches `adv_pending` after 3 edges (2 sync + 1 edge detect). A press arriving during the frame-start cycle itself takes effect at the following frame.
- **Reset mid-frame:**
  - Outputs go to their reset values immediately.
  - After release, the first frame start counts as frame 0.
  - The first auto-advance happens at the `FRAMES_PER_PATTERN`-th frame start.
- **`FRAMES_PER_PATTERN`=1:** the pattern advances at every frame start.

## Structure
- Shared package `vga_pkg`:
  - `H_VISIBLE`, `V_VISIBLE` defaults.
  - Pattern codes `PAT_BARS`=0, `PAT_CHECKER`=1, `PAT_GRID`=2, `PAT_BORDER`=3.
  - `vga_controller` and this block both use it.
- Sub-module `vga_pattern_gen`: purely combinational; takes `pattern`, `row`, `col`, `visible` and returns `{R,G,B}`.
- The sequencer owns all registers: synchronizer, counter, state machine, output pipeline.

## Test plan
- **Reset release:** with `hold`=0 and no button, run 30 frames (`v_sync` falling edges). Expect `pattern`=1 exactly on the 30th `frame_tick`, and `pattern`=0 before it.
- **Manual advance:** pulse `advance` for 4 cycles mid-frame 5. Expect `pattern` 0→1 at the frame-5→6 start, with `frame_cnt` back to 0; the next auto-advance comes 30 frames later.
- **Coincident events:** press `advance` in frame 29. Expect a single step 0→1, not 0→2.
- **Hold and wrap:**
  - `hold`=1 for 100 frames: `pattern` stays constant.
  - Four button presses across four frames: `pattern` goes 0,1,2,3,0.
- **Pixel check:** drive `pattern`=BARS with `row`=300, `visible`=1. Expect `{R,G,B}`=3'b101 one cycle later; `visible`=0 gives 0. For BORDER, `row`=320 gives `G`=1.
- **Reset mid-frame:** assert `reset` at `pattern`=2, `frame_cnt`=17. Expect RGB=0, `h_sync_q`=`v_sync_q`=1 and `pattern`=0 asynchronously, with the count restarting from 0 after release.
